// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
// Optional macro FETCH_BYPASS_EN is consumed by if_fetch_buffer.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] NOP = 32'h0000_0013;

    // One queue slot: PC written at issue, instruction written at response.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  filled;
    } fetch_entry_t;

    // Slot index plus one wrap bit, so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order fetch queue: allocate at issue, fill on response, pop at head.
// Flush (clear) discards every entry and collapses head/fill onto alloc.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  alloc_en,
    input  logic [FETCH_XLEN-1:0] alloc_pc,
    input  logic                  fill_en,
    input  logic [FETCH_XLEN-1:0] fill_instr,
    input  logic                  pop_en,
    output fetch_entry_t          head,
    output logic                  fill_at_head,
    output logic [PW-1:0]         count,
    output logic [PW-1:0]         pending
);

    localparam int IW = $clog2(DEPTH);

    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    fetch_entry_t  mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            // NOTE: storage is reset because Instr/Instr_PC are read straight from the head slot and must be 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            fill_ptr <= alloc_ptr;
            head_ptr <= alloc_ptr;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_en) begin
                mem[alloc_ptr[IW-1:0]].pc <= alloc_pc;
                alloc_ptr                 <= alloc_ptr + PW'(1);
            end
            if (fill_en) begin
                mem[fill_ptr[IW-1:0]].instr  <= fill_instr;
                mem[fill_ptr[IW-1:0]].filled <= 1'b1;
                fill_ptr                     <= fill_ptr + PW'(1);
            end
            // Last write wins, so a bypassed fill+pop of one slot leaves it empty.
            if (pop_en) begin
                mem[head_ptr[IW-1:0]].filled <= 1'b0;
                head_ptr                     <= head_ptr + PW'(1);
            end
        end
    end

    assign head         = mem[head_ptr[IW-1:0]];
    assign fill_at_head = (fill_ptr == head_ptr);
    assign count        = alloc_ptr - head_ptr;
    assign pending      = alloc_ptr - fill_ptr;

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer between the PC unit and instruction memory: issue, drop-after-flush, decode queue.
// Define FETCH_BYPASS_EN for zero-latency forwarding of a response that lands at the empty head.
module if_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN  = FETCH_XLEN,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] PC,
    input  logic            PC_valid,
    output logic            PC_stall,
    input  logic            Flush,
    output logic            IMEM_req,
    output logic [XLEN-1:0] IMEM_addr,
    input  logic            IMEM_gnt,
    input  logic            IMEM_rvalid,
    input  logic [XLEN-1:0] IMEM_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] Instr_PC,
    output logic            Instr_valid,
    input  logic            Decode_ready
);

    localparam int            PW    = ptr_width(DEPTH);
    localparam logic [PW:0]   LIMIT = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] ONE   = PW'(1);

    fetch_entry_t  head;
    logic          fill_at_head;
    logic [PW-1:0] count;
    logic [PW-1:0] pending;
    logic [PW-1:0] drop_cnt;
    logic [PW:0]   occupancy;
    logic          full;
    logic          dropping;
    logic          rsp_legal;
    logic          issue;
    logic          fill_en;
    logic          pop_en;
    logic          bypass;

    // Responses still owed to dropped requests occupy memory slots too.
    assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
    assign full      = (occupancy >= LIMIT);
    assign dropping  = (drop_cnt != '0);
    assign rsp_legal = IMEM_rvalid & ((pending != '0) | dropping);

    assign IMEM_req  = RST & PC_valid & ~full & ~Flush;
    assign IMEM_addr = PC;
    assign issue     = IMEM_req & IMEM_gnt;
    assign PC_stall  = RST & PC_valid & ~issue;
    assign fill_en   = rsp_legal & ~dropping & ~Flush;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        bypass      = 1'b0;
        Instr_valid = head.filled;
        Instr       = head.instr;
        Instr_PC    = head.pc;
`ifdef FETCH_BYPASS_EN
        bypass = ~head.filled & fill_en & fill_at_head;
        if (bypass) begin
            Instr_valid = 1'b1;
            Instr       = IMEM_rdata;
        end
`endif
        pop_en = Instr_valid & Decode_ready & ~Flush;
    end

    if_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (CLK),
        .rst_n        (RST),
        .clear        (Flush),
        .alloc_en     (issue),
        .alloc_pc     (PC),
        .fill_en      (fill_en),
        .fill_instr   (IMEM_rdata),
        .pop_en       (pop_en),
        .head         (head),
        .fill_at_head (fill_at_head),
        .count        (count),
        .pending      (pending)
    );

    // A response arriving with the flush is already home, so it is not counted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            drop_cnt <= '0;
        end else if (Flush) begin
            drop_cnt <= drop_cnt + pending - (rsp_legal ? ONE : '0);
        end else if (rsp_legal && dropping) begin
            drop_cnt <= drop_cnt - ONE;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (!RST)
        IMEM_rvalid |-> ((pending != '0) || dropping));

endmodule
